// File: rtl/serial_tx_pkg.sv
// Shared types for the two-requester serial transmit arbiter.
// State literals carry an ST_ prefix so they never collide with the GAP parameter.
package serial_tx_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_t;

  typedef logic [$clog2(NUM_REQ)-1:0] req_id_t;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in / serial-out shift register, LSB first, zero-filled from the top.
module piso_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout
);

  logic [WIDTH-1:0] shreg;

  // load wins over shift so a new word is never corrupted on its capture edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= din;
    end else if (shift) begin
      shreg <= {1'b0, shreg[WIDTH-1:1]};
    end
  end

  assign sout = shreg[0];

endmodule

// File: rtl/serial_tx_arbiter.sv
// Round-robin scheduler of two valid/ready word sources onto one serializer,
// with a programmable idle gap after every frame.
module serial_tx_arbiter
  import serial_tx_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             grant_id,
  output logic             frame_done,
  output logic             busy
);

  localparam int BCW = $clog2(WIDTH);
  localparam int GCW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
  localparam logic [GCW-1:0] GAP_LAST = GCW'((GAP > 0) ? GAP - 1 : 0);

  state_t         state, state_nx;
  logic [BCW-1:0] bit_cnt, bit_cnt_nx;
  logic [GCW-1:0] gap_cnt, gap_cnt_nx;
  req_id_t        last_grant, grant_q, sel;
  logic           accept, load, shift, sr_out;
  logic [WIDTH-1:0] win_data;

  always_comb begin
    sel = 1'b0;
    if (req0_valid && req1_valid) begin
      sel = ~last_grant;
    end else if (req1_valid) begin
      sel = 1'b1;
    end
  end

  // ready is gated by rst_n so nothing is offered while reset is held
  assign req0_ready = rst_n && (state == ST_IDLE) && req0_valid && (sel == 1'b0);
  assign req1_ready = rst_n && (state == ST_IDLE) && req1_valid && (sel == 1'b1);
  assign accept     = req0_ready | req1_ready;
  assign win_data   = sel ? req1_data : req0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      last_grant <= 1'b1;
      grant_q    <= 1'b0;
    end else begin
      state   <= state_nx;
      bit_cnt <= bit_cnt_nx;
      gap_cnt <= gap_cnt_nx;
      if (accept) begin
        last_grant <= sel;
        grant_q    <= sel;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    gap_cnt_nx = gap_cnt;
    load       = 1'b0;
    shift      = 1'b0;
    sout       = 1'b0;
    sout_valid = 1'b0;
    frame_done = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (accept) begin
          load       = 1'b1;
          bit_cnt_nx = '0;
          state_nx   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift      = 1'b1;
        sout       = sr_out;
        sout_valid = 1'b1;
        frame_done = (bit_cnt == BIT_LAST);
        if (bit_cnt == BIT_LAST) begin
          bit_cnt_nx = '0;
          gap_cnt_nx = '0;
          state_nx   = (GAP > 0) ? ST_GAP : ST_IDLE;
        end else begin
          bit_cnt_nx = bit_cnt + BCW'(1);
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          gap_cnt_nx = '0;
          state_nx   = ST_IDLE;
        end else begin
          gap_cnt_nx = gap_cnt + GCW'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign grant_id = grant_q;

  piso_shift_reg #(.WIDTH(WIDTH)) u_piso (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .shift (shift),
    .din   (win_data),
    .sout  (sr_out)
  );

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Directed bench for serial_tx_arbiter: a WIDTH=4/GAP=1 instance plus a GAP=0 build.
module tb_serial_tx_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_data, req1_data;
  logic       req0_ready, req1_ready, sout, sout_valid, grant_id, frame_done, busy;

  logic       z0_valid, z1_valid;
  logic [3:0] z0_data, z1_data;
  logic       z0_ready, z1_ready, z_sout, z_sout_valid, z_grant_id, z_frame_done, z_busy;

  int nchk = 0;
  int nerr = 0;

  serial_tx_arbiter #(.WIDTH(4), .GAP(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .sout       (sout),
    .sout_valid (sout_valid),
    .grant_id   (grant_id),
    .frame_done (frame_done),
    .busy       (busy)
  );

  serial_tx_arbiter #(.WIDTH(4), .GAP(0)) dut_g0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (z0_valid),
    .req0_data  (z0_data),
    .req0_ready (z0_ready),
    .req1_valid (z1_valid),
    .req1_data  (z1_data),
    .req1_ready (z1_ready),
    .sout       (z_sout),
    .sout_valid (z_sout_valid),
    .grant_id   (z_grant_id),
    .frame_done (z_frame_done),
    .busy       (z_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for the given requester's ready, then checks the whole frame and its gap cycle.
  task automatic do_frame(input logic id, input logic [3:0] w, input logic nv,
                          input logic [3:0] nd, input int exp_wait);
    int n = 0;
    while (!(id ? req1_ready : req0_ready) && n < 12) begin
      @(negedge clk); #1;
      n++;
    end
    chk("ready_wait", n, exp_wait);
    chk("other_ready", id ? req0_ready : req1_ready, 1'b0);
    for (int b = 0; b < 4; b++) begin
      @(negedge clk); #1;
      if (b == 0) begin
        if (id) begin req1_valid = nv; req1_data = nd; end
        else    begin req0_valid = nv; req0_data = nd; end
      end
      chk("sout", sout, w[b]);
      chk("sout_valid", sout_valid, 1'b1);
      chk("frame_done", frame_done, (b == 3));
      chk("grant_id", grant_id, id);
      chk("ready_in_shift", req0_ready | req1_ready, 1'b0);
    end
    @(negedge clk); #1;
    chk("gap_sout_valid", sout_valid, 1'b0);
    chk("gap_sout", sout, 1'b0);
    chk("gap_busy", busy, 1'b1);
    chk("gap_ready", req0_ready | req1_ready, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    logic [3:0] gw [3];
    gw[0] = 4'h6; gw[1] = 4'h9; gw[2] = 4'h3;

    rst_n = 1'b0;
    req0_valid = 1'b1; req0_data = 4'b1011;
    req1_valid = 1'b1; req1_data = 4'h5;
    z0_valid = 1'b0; z0_data = 4'h0; z1_valid = 1'b0; z1_data = 4'h0;

    // Reset held with both requesters valid
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);
    chk("rst_sout", sout, 1'b0);
    chk("rst_sout_valid", sout_valid, 1'b0);
    chk("rst_grant_id", grant_id, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1; #1;
    chk("rel_ready0", req0_ready, 1'b1);
    chk("rel_ready1", req1_ready, 1'b0);

    // Single frame 1011 from requester 0, valid dropped after acceptance
    req1_valid = 1'b0; #1;
    do_frame(1'b0, 4'b1011, 1'b0, 4'b1011, 0);
    @(negedge clk); #1;
    chk("idle_busy", busy, 1'b0);
    req0_valid = 1'b1; #1;
    chk("ready_after_gap", req0_ready, 1'b1);
    req0_valid = 1'b0; #1;
    chk("dropped_valid_ready", req0_ready, 1'b0);
    @(negedge clk); #1;
    chk("no_capture_busy", busy, 1'b0);
    chk("no_capture_sout_valid", sout_valid, 1'b0);

    // Requester 1 alone, back-to-back words
    req1_valid = 1'b1; req1_data = 4'h1; #1;
    do_frame(1'b1, 4'h1, 1'b1, 4'h2, 0);
    do_frame(1'b1, 4'h2, 1'b1, 4'h3, 1);
    do_frame(1'b1, 4'h3, 1'b0, 4'h0, 1);

    // Contention: alternating grants
    req0_valid = 1'b1; req0_data = 4'hA;
    req1_valid = 1'b1; req1_data = 4'h5; #1;
    do_frame(1'b0, 4'hA, 1'b1, 4'hA, 1);
    do_frame(1'b1, 4'h5, 1'b1, 4'h5, 1);
    do_frame(1'b0, 4'hA, 1'b1, 4'hA, 1);
    do_frame(1'b1, 4'h5, 1'b1, 4'h5, 1);

    // Reset during the second bit of a requester-1 frame
    req0_valid = 1'b0; #1;
    n = 0;
    while (!req1_ready && n < 12) begin
      @(negedge clk); #1;
      n++;
    end
    chk("mf_wait", n, 1);
    @(negedge clk); #1;
    chk("mf_bit0", sout, 1'b1);
    chk("mf_bit0_valid", sout_valid, 1'b1);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("mf_sout_valid", sout_valid, 1'b0);
    chk("mf_sout", sout, 1'b0);
    chk("mf_busy", busy, 1'b0);
    chk("mf_grant_id", grant_id, 1'b0);
    chk("mf_frame_done", frame_done, 1'b0);
    req0_valid = 1'b1; req0_data = 4'hC;
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk("mf_rel_ready0", req0_ready, 1'b1);
    chk("mf_rel_ready1", req1_ready, 1'b0);
    do_frame(1'b0, 4'hC, 1'b0, 4'h0, 0);
    req1_valid = 1'b0;

    // GAP=0 build: continuous requester-0 traffic, period 5
    z0_valid = 1'b1; z0_data = gw[0]; #1;
    n = 0;
    while (!z0_ready && n < 12) begin
      @(negedge clk); #1;
      n++;
    end
    chk("g0_wait", n, 0);
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 4; b++) begin
        @(negedge clk); #1;
        if (b == 0 && f < 2) z0_data = gw[f+1];
        chk("g0_sout", z_sout, gw[f][b]);
        chk("g0_sout_valid", z_sout_valid, 1'b1);
        chk("g0_frame_done", z_frame_done, (b == 3));
        chk("g0_ready_in_shift", z0_ready, 1'b0);
      end
      @(negedge clk); #1;
      chk("g0_accept_sout_valid", z_sout_valid, 1'b0);
      chk("g0_accept_ready", z0_ready, 1'b1);
      chk("g0_accept_busy", z_busy, 1'b0);
    end
    z0_valid = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
